// File: rtl/sevenseg_scan_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_pkg
// Shared constants for the seven-segment display path: the layout of a 7-bit
// digit code, the active-low segment table and the digit-index type.
//
// Digit code layout:
//   [3:0] hex value
//   [4]   reserved, ignored
//   [5]   decimal point on
//   [6]   blank
// -----------------------------------------------------------------------------
package sevenseg_scan_pkg;

    localparam int NUM_DIGITS = 8;

    localparam int VAL_MSB   = 3;
    localparam int RSVD_BIT  = 4;
    localparam int DP_BIT    = 5;
    localparam int BLANK_BIT = 6;

    // Idle pin levels; every display-board pin is active-low.
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       DP_OFF  = 1'b1;

    typedef logic [2:0] digit_idx_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}, indexed by value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // Active-low anode pattern with only the selected digit enabled.
    function automatic logic [7:0] anode_for(input digit_idx_t idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/sevenseg_scan_seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Purely combinational hex-to-seven-segment decoder (active-low outputs).
//
// Ports:
//   i_val  in   4  hex value
//   o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg_decode
    import sevenseg_scan_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_val];

endmodule

// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
// Time-multiplexed 8-digit seven-segment driver. Each digit owns a slot of
// TICK_CLKS clocks; the first GUARD_CLKS clocks of a slot keep every anode off
// to stop ghosting, then the digit code is sampled once and held until the
// slot ends. Digits selected in blink_mask are blanked during the odd blink
// phase, which toggles every BLINK_FRAMES complete scans.
//
// Intended wiring from dig_clock: s0->d0, s1->d1, m0->d2, m1->d3, h0->d4,
// h1->d5, am_pm->d7, with d6 tied to 7'h40 (blank).
//
// Ports:
//   clk         in   1  system clock
//   rst         in   1  synchronous active-high reset
//   d0..d7      in   7  digit codes, d0 is the rightmost digit (an[0])
//   blink_mask  in   8  bit i set makes digit i blink
//   an          out  8  anode enables, active-low, at most one low
//   seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point, active-low
// -----------------------------------------------------------------------------
module sevenseg_scan
    import sevenseg_scan_pkg::*;
#(
    parameter int TICK_CLKS    = 100_000,
    parameter int GUARD_CLKS   = 100,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] d0,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    input  logic [6:0] d4,
    input  logic [6:0] d5,
    input  logic [6:0] d6,
    input  logic [6:0] d7,
    input  logic [7:0] blink_mask,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CLKS - 1);
    // Load happens on the edge leaving the last guard count.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CLKS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_cnt;
    digit_idx_t       r_idx;
    logic [FRM_W-1:0] r_frame;
    logic             r_blink_phase;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic [6:0]       w_sel;
    logic [6:0]       w_seg_dec;
    logic             w_blank;
    logic             w_slot_end;
    logic             w_load;
    logic             w_unused_rsvd;

    // Current slot's digit code.
    always_comb begin
        w_sel = d0;
        case (r_idx)
            3'd0:    w_sel = d0;
            3'd1:    w_sel = d1;
            3'd2:    w_sel = d2;
            3'd3:    w_sel = d3;
            3'd4:    w_sel = d4;
            3'd5:    w_sel = d5;
            3'd6:    w_sel = d6;
            default: w_sel = d7;
        endcase
    end

    // The reserved code bit carries no meaning here.
    assign w_unused_rsvd = w_sel[RSVD_BIT];

    seg_decode u_seg_decode (
        .i_val (w_sel[VAL_MSB:0]),
        .o_seg (w_seg_dec)
    );

    assign w_blank    = w_sel[BLANK_BIT] | (blink_mask[r_idx] & r_blink_phase);
    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_load     = (r_cnt == CNT_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
            r_an          <= AN_OFF;
            r_seg         <= SEG_OFF;
            r_dp          <= DP_OFF;
        end else if (w_slot_end) begin
            // Slot boundary: advance digit, blank pins for the guard interval.
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= DP_OFF;
            if (r_idx == 3'd7) begin
                if (r_frame == FRM_LAST) begin
                    r_frame       <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
            // GUARD_CLKS < TICK_CLKS keeps the load edge distinct from the
            // slot-end edge, so the guard blanking above never collides.
            if (w_load) begin
                if (w_blank) begin
                    r_an  <= AN_OFF;
                    r_seg <= SEG_OFF;
                    r_dp  <= DP_OFF;
                end else begin
                    r_an  <= anode_for(r_idx);
                    r_seg <= w_seg_dec;
                    r_dp  <= ~w_sel[DP_BIT];
                end
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
